// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants used across the pipeline.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // Fetch-stage control states.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } lc3b_fetch_state;

  localparam lc3b_word lc3b_pc_incr = 16'd2;

  // Word-align an instruction address (LC-3b instructions are 2 bytes).
  function automatic lc3b_word lc3b_align(input lc3b_word addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry {ir, pc, valid} register that parks a fetched word while the
// IF/ID barrier is stalled.
module fetch_hold_buffer
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     i_clear,
  input  logic     i_load,
  input  lc3b_word i_ir,
  input  lc3b_word i_pc,
  output lc3b_word o_ir,
  output lc3b_word o_pc,
  output logic     o_valid
);

  lc3b_word r_ir;
  lc3b_word r_pc;
  logic     r_valid;

  // Capture on load; reset and clear both invalidate the entry.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    if (reset || i_clear) begin
      r_ir    <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_ir    <= i_ir;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_ir    = r_ir;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b IF stage: owns the fetch PC, runs the I-cache read handshake, and
// presents {ir, pc, valid} to the IF/ID barrier. Stalls are absorbed by a
// one-entry hold buffer; redirects during an outstanding miss are parked
// until the cache answers, so the request address never changes mid-flight.
module fetch_stage
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     stall,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  input  logic     imem_resp,
  input  lc3b_word imem_rdata,
  output logic     imem_read,
  output lc3b_word imem_address,
  output lc3b_word ir_out,
  output lc3b_word pc_out,
  output logic     valid_out
);

  lc3b_fetch_state r_state;
  lc3b_word        r_pc;
  lc3b_word        r_pending;

  lc3b_word w_pc_incr;
  lc3b_word w_target;
  logic     w_hold_load;
  logic     w_hold_clear;
  lc3b_word w_hold_ir;
  lc3b_word w_hold_pc;
  logic     w_hold_valid;

  assign w_pc_incr = r_pc + lc3b_pc_incr;
  assign w_target  = lc3b_align(redirect_pc);

  // Park the word when it arrives into a stalled barrier; drop it when the
  // barrier takes it or a redirect kills it.
  assign w_hold_load  = (r_state == FETCH) && imem_resp && !redirect && stall;
  assign w_hold_clear = (r_state == HOLD) && (redirect || !stall);

  fetch_hold_buffer u_hold (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_hold_clear),
    .i_load  (w_hold_load),
    .i_ir    (imem_rdata),
    .i_pc    (w_pc_incr),
    .o_ir    (w_hold_ir),
    .o_pc    (w_hold_pc),
    .o_valid (w_hold_valid)
  );

  // State, PC and pending-redirect update; redirect outranks everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_pc      <= lc3b_align(RESET_PC);
      r_pending <= '0;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (imem_resp) begin
            if (redirect) begin
              r_pc <= w_target;
            end else begin
              r_pc <= w_pc_incr;
              if (stall) r_state <= HOLD;
            end
          end else if (redirect) begin
            r_pending <= w_target;
            r_state   <= SQUASH;
          end
        end
        HOLD: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_state <= FETCH;
          end else if (!stall) begin
            r_state <= FETCH;
          end
        end
        SQUASH: begin
          if (imem_resp) begin
            r_pc    <= redirect ? w_target : r_pending;
            r_state <= FETCH;
          end else if (redirect) begin
            r_pending <= w_target;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // Handshake and barrier outputs; a fetched word bypasses straight through.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would infer a latch.
    imem_read    = 1'b0;
    imem_address = r_pc;
    ir_out       = imem_rdata;
    pc_out       = w_pc_incr;
    valid_out    = 1'b0;
    unique case (r_state)
      FETCH: begin
        imem_read = 1'b1;
        valid_out = imem_resp && !redirect;
      end
      HOLD: begin
        ir_out    = w_hold_ir;
        pc_out    = w_hold_pc;
        valid_out = w_hold_valid && !redirect;
      end
      SQUASH: begin
        imem_read = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      imem_read = 1'b0;
      valid_out = 1'b0;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the pipelined LC-3b core.
- Owns the fetch PC and drives the instruction-memory (I-cache) read handshake.
- Presents {ir, pc, valid} to the IF/ID barrier.
- Absorbs downstream stalls with a one-entry hold buffer, and absorbs branch/flush redirects that arrive while a cache request is in flight.

Parameters:
- RESET_PC, 16'h0000, fetch address loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  IF/ID barrier will not load this cycle.
- redirect  in  1  flush and re-fetch; from EX/MEM branch, jump or trap resolution.
- redirect_pc  in  16  redirect target; bit 0 ignored, forced to 0.
- imem_resp  in  1  I-cache read complete this cycle.
- imem_rdata  in  16  instruction word, valid when imem_resp=1.
- imem_read  out  1  read request; held until imem_resp.
- imem_address  out  16  fetch address; stable while imem_read=1 and no imem_resp.
- ir_out  out  16  instruction to the IF/ID barrier.
- pc_out  out  16  fetch address + 2 (LC-3b incremented PC).
- valid_out  out  1  ir_out/pc_out hold a real instruction.

Behaviour:
- Reset (synchronous, active-high):
  - pc <= RESET_PC, state <= FETCH, hold buffer cleared, pending target <= 0.
  - While reset=1, imem_read=0 and valid_out=0 (forced).
  - Reset mid-request abandons the transaction; the I-cache is reset in the same cycle.
- States: FETCH, HOLD, SQUASH.
- Priority in every state: redirect > imem_resp/stall handling.
- FETCH:
  - imem_read=1, imem_address=pc.
  - imem_resp=1 and redirect=1: discard data; valid_out=0; pc <= redirect_pc; stay FETCH.
  - imem_resp=1 and no redirect: valid_out=1 (combinational), ir_out=imem_rdata, pc_out=pc+2; pc <= pc+2.
    - If stall=0, stay FETCH; zero-bubble back-to-back fetch.
    - If stall=1, capture {imem_rdata, pc+2} into the hold buffer and go to HOLD.
  - imem_resp=0 and redirect=1: address must stay stable, so latch pending <= redirect_pc and go to SQUASH; valid_out=0.
  - imem_resp=0 and no redirect: stay FETCH; valid_out=0.
- HOLD:
  - imem_read=0; valid_out=1; ir_out/pc_out come from the hold buffer.
  - redirect=1: drop the held word; valid_out=0 this cycle; pc <= redirect_pc; go to FETCH.
  - stall=0: barrier consumes the word this edge; go to FETCH (new request next cycle).
  - stall=1: remain in HOLD; outputs unchanged.
- SQUASH:
  - imem_read=1, imem_address=pc (the old address); valid_out=0 always.
  - redirect=1 with no resp: pending <= redirect_pc (latest redirect wins).
  - imem_resp=1: discard data; pc <= (redirect ? redirect_pc : pending); go to FETCH.
- Arithmetic:
  - pc+2 is 16-bit modular: 16'hFFFE + 2 = 16'h0000.
  - Every loaded pc has bit 0 = 0.
- stall is ignored whenever valid_out=0, since no word is produced.
- Latency: minimum one cycle per instruction on an I-cache hit that returns in the request cycle.

Decomposition:
- Package lc3b_types (shared) holds:
  - lc3b_word (existing)
  - new enum lc3b_fetch_state {FETCH, HOLD, SQUASH}
  - constant lc3b_pc_incr = 16'd2
- One natural sub-module: fetch_hold_buffer.
  - Load-enabled {ir, pc, valid} register with synchronous clear.
  - Instantiated once for the HOLD entry.
- The next-state and output logic stays in fetch_stage.

Test Plan:
- Reset then hit stream:
  - Stimulus: reset 2 cycles, RESET_PC=0; imem_resp=1 every cycle; rdata 16'h1261, 16'h1402, 16'h0FFD; stall=0.
  - Expected: addresses 0, 2, 4 on consecutive cycles; pc_out 2, 4, 6; valid_out=1 each cycle.
- Stall on response:
  - Stimulus: resp with rdata 16'hABCD at pc=16'h0010 while stall=1 for 3 cycles.
  - Expected: HOLD; imem_read=0; ir_out=16'hABCD, pc_out=16'h0012 held 3 cycles; release leads to the next request at 16'h0012.
- Redirect during miss:
  - Stimulus: request at 16'h0020 with resp delayed 4 cycles; redirect to 16'h3001 in cycle 1.
  - Expected: imem_address stays 16'h0020 until resp; returned data discarded (valid_out=0); next request at 16'h3000.
- Double redirect in SQUASH:
  - Stimulus: redirects to 16'h0100 then 16'h0200 before resp.
  - Expected: post-resp fetch at 16'h0200.
- Redirect coincident with resp, and redirect in HOLD with stall=1:
  - Expected: data dropped; valid_out=0; pc=redirect_pc next cycle; hold buffer invalidated.
- Wrap and reset mid-miss:
  - Stimulus: fetch at 16'hFFFE; separately, assert reset during an outstanding request.
  - Expected: pc_out=16'h0000 and the next fetch is at 16'h0000; reset mid-miss leaves imem_read=0 and valid_out=0 that cycle, then a request at RESET_PC.
